clock_disp_scanner: RTL

Parametrised successor to the six-display clock decoder: accepts binary hours/minutes/seconds and drives a single time-multiplexed 6-digit 7-segment bank with one shared segment bus and a one-hot digit select. It adds a 12/24-hour display mode, per-group blinking for time-set mode, range checking, and a frame-aligned input snapshot that prevents tearing. It sits between the timekeeping counters and the board display pins.

---
 rtl/clock_disp_scanner.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/clock_disp_scanner.sv
// Time-multiplexed 6-digit 7-segment driver for an hh:mm:ss clock.
// Inputs are snapshotted once per frame so a displayed frame never tears.
module clock_disp_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int BLINK_FRAMES   = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [4:0] hours_i,
    input  logic [5:0] minutes_i,
    input  logic [5:0] seconds_i,
    input  logic       mode12_i,
    input  logic [2:0] blink_mask_i,
    output logic [6:0] seg_o,
    output logic [5:0] dig_sel_o,
    output logic       pm_o,
    output logic       err_o,
    output logic       frame_tick_o
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [6:0] DASH  = 7'h40;
    localparam logic [6:0] UNLIT = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    logic [CW-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]    dig_idx_q, dig_idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [4:0]    snap_hr_q;
    logic [5:0]    snap_min_q, snap_sec_q;
    logic          snap_m12_q;
    logic [2:0]    snap_mask_q;

    logic          last_cnt, wrap;
    logic [4:0]    hr_disp;
    logic [3:0]    hr_ten, hr_one, min_ten, min_one, sec_ten, sec_one;
    logic [2:0]    grp_ok;
    logic [3:0]    cur_dig;
    logic [2:0]    cur_grp;
    logic          blank_tens;
    logic [6:0]    lit;
    logic [6:0]    seg_d;
    logic [5:0]    dig_sel_d;
    logic          pm_d, err_d;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign last_cnt = (scan_cnt_q == CW'(SCAN_DIV - 1));
    assign wrap     = last_cnt && (dig_idx_q == 3'd5);

    // Scan position and blink timebase
    always_comb begin
        scan_cnt_d    = scan_cnt_q + 1'b1;
        dig_idx_d     = dig_idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (last_cnt) begin
            scan_cnt_d = '0;
            dig_idx_d  = (dig_idx_q == 3'd5) ? 3'd0 : dig_idx_q + 3'd1;
        end
        if (wrap) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        hr_disp = snap_hr_q;
        if (snap_m12_q) begin
            if (snap_hr_q == 5'd0)       hr_disp = 5'd12;
            else if (snap_hr_q > 5'd12)  hr_disp = snap_hr_q - 5'd12;
        end
    end

    assign hr_ten  = 4'(hr_disp / 5'd10);
    assign hr_one  = 4'(hr_disp % 5'd10);
    assign min_ten = 4'(snap_min_q / 6'd10);
    assign min_one = 4'(snap_min_q % 6'd10);
    assign sec_ten = 4'(snap_sec_q / 6'd10);
    assign sec_one = 4'(snap_sec_q % 6'd10);
    assign grp_ok  = {snap_hr_q < 5'd24, snap_min_q < 6'd60, snap_sec_q < 6'd60};

    // Digit content; cur_grp is one-hot {hours, minutes, seconds}
    always_comb begin
        cur_dig    = '0;
        cur_grp    = 3'b001;
        blank_tens = 1'b0;
        case (dig_idx_q)
            3'd0: begin cur_dig = sec_one; cur_grp = 3'b001; end
            3'd1: begin cur_dig = sec_ten; cur_grp = 3'b001; end
            3'd2: begin cur_dig = min_one; cur_grp = 3'b010; end
            3'd3: begin cur_dig = min_ten; cur_grp = 3'b010; end
            3'd4: begin cur_dig = hr_one;  cur_grp = 3'b100; end
            3'd5: begin
                cur_dig    = hr_ten;
                cur_grp    = 3'b100;
                blank_tens = snap_m12_q && (hr_ten == 4'd0);
            end
            default: ;
        endcase

        if (blink_phase_q && |(cur_grp & snap_mask_q)) lit = 7'h00;
        else if (~|(cur_grp & grp_ok))                 lit = DASH;
        else if (blank_tens)                           lit = 7'h00;
        else                                           lit = seg7(cur_dig);

        seg_d     = SEG_ACTIVE_LOW ? ~lit : lit;
        dig_sel_d = 6'b000001 << dig_idx_q;
        pm_d      = snap_m12_q && grp_ok[2] && (snap_hr_q >= 5'd12);
        err_d     = ~&grp_ok;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            scan_cnt_q    <= '0;
            dig_idx_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            snap_hr_q     <= '0;
            snap_min_q    <= '0;
            snap_sec_q    <= '0;
            snap_m12_q    <= 1'b0;
            snap_mask_q   <= '0;
            seg_o         <= UNLIT;
            dig_sel_o     <= '0;
            pm_o          <= 1'b0;
            err_o         <= 1'b0;
            frame_tick_o  <= 1'b0;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            dig_idx_q     <= dig_idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            if (wrap) begin
                snap_hr_q   <= hours_i;
                snap_min_q  <= minutes_i;
                snap_sec_q  <= seconds_i;
                snap_m12_q  <= mode12_i;
                snap_mask_q <= blink_mask_i;
            end
            seg_o        <= seg_d;
            dig_sel_o    <= dig_sel_d;
            pm_o         <= pm_d;
            err_o        <= err_d;
            frame_tick_o <= wrap;
        end
    end
endmodule
